// File: rtl/cpu_trace_monitor.sv
// Passive retirement tracer for the multi-cycle CPU debug bus: captures {pc, inst, writeback}
// per retired instruction into a show-ahead FIFO, with cycle/retire/drop counters and halt detect.
module cpu_trace_monitor #(
  parameter int         DEPTH   = 8,
  parameter logic [2:0] Q_IF    = 3'b000,
  parameter logic [2:0] Q_ID    = 3'b001,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [2:0]  q,
  input  logic        RegWre,
  input  logic [31:0] ALUout,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [31:0] tr_pc,
  output logic [31:0] tr_inst,
  output logic        tr_wb,
  output logic [31:0] tr_wbval,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt,
  output logic [7:0]  drop_cnt,
  output logic        overflow,
  output logic        halted,
  output logic [1:0]  state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

  state_t state_q, state_d;
  logic   running;

  logic [2:0]  q_prev_q;
  logic        id_seen_q;
  logic [31:0] cap_pc_q, cap_inst_q, cap_wbval_q;
  logic        cap_wb_q;
  logic [31:0] cycle_cnt_q, retire_cnt_q;
  logic [7:0]  drop_cnt_q;
  logic        overflow_q;

  logic [96:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [96:0] head;
  logic        empty, full, pop, push_ok, drop, retire, is_halt;

  // A retirement is the Q_IF entry edge that follows a decode capture.
  assign retire  = running && (q_prev_q != Q_IF) && (q == Q_IF) && id_seen_q;
  assign is_halt = (cap_inst_q[31:26] == HALT_OP);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (q == Q_IF) state_d = S_RUN;
      S_RUN:   if (retire && is_halt) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state_q == S_RUN);
    halted  = (state_q == S_HALT);
    state_o = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_prev_q    <= '0;
      id_seen_q   <= 1'b0;
      cap_pc_q    <= '0;
      cap_inst_q  <= '0;
      cap_wb_q    <= 1'b0;
      cap_wbval_q <= '0;
    end else begin
      q_prev_q <= q;
      if (running) begin
        if (retire) id_seen_q <= 1'b0;
        if (q == Q_ID) begin
          cap_pc_q    <= pc;
          cap_inst_q  <= inst;
          cap_wb_q    <= 1'b0;
          cap_wbval_q <= '0;
          id_seen_q   <= 1'b1;
        end
        // Later writes overwrite earlier ones; only the final writeback is recorded.
        if (RegWre && (q != Q_IF)) begin
          cap_wb_q    <= 1'b1;
          cap_wbval_q <= ALUout;
        end
      end
    end
  end

  // Valid/ready: a record transfers on any edge where tr_valid && tr_ready; tr_* hold while
  // tr_valid && !tr_ready. A push into a full FIFO only succeeds if the head pops that cycle.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && tr_ready;
  assign push_ok = retire && (!full || pop);
  assign drop    = retire && full && !pop;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {cap_pc_q, cap_inst_q, cap_wb_q, cap_wbval_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)     rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      if (running) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire)  retire_cnt_q <= retire_cnt_q + 32'd1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign tr_valid   = !empty;
  assign tr_pc      = tr_valid ? head[96:65] : 32'd0;
  assign tr_inst    = tr_valid ? head[64:33] : 32'd0;
  assign tr_wb      = tr_valid ? head[32]    : 1'b0;
  assign tr_wbval   = tr_valid ? head[31:0]  : 32'd0;
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: drives the CPU debug bus through instruction
// sequences and checks trace records, counters, overflow and halt behaviour.
module tb_cpu_trace_monitor;
  localparam int DEPTH = 8;
  localparam logic [2:0] Q_IF = 3'b000;
  localparam logic [2:0] Q_ID = 3'b001;

  logic        clk, rst_n;
  logic [31:0] pc, inst, ALUout;
  logic [2:0]  q;
  logic        RegWre, tr_ready;
  logic        tr_valid, tr_wb, overflow, halted;
  logic [31:0] tr_pc, tr_inst, tr_wbval, cycle_cnt, retire_cnt;
  logic [7:0]  drop_cnt;
  logic [1:0]  state_o;

  int          total = 0;
  int          bad = 0;
  int          exp_cycles = 0;
  bit          model_run = 0;
  logic [96:0] exp_q[$];

  cpu_trace_monitor #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .q(q), .RegWre(RegWre),
    .ALUout(ALUout), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc),
    .tr_inst(tr_inst), .tr_wb(tr_wb), .tr_wbval(tr_wbval), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
    .halted(halted), .state_o(state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [96:0] mk(input logic [31:0] p, input logic [31:0] i,
                                     input logic w, input logic [31:0] v);
    return {p, i, w, v};
  endfunction

  // Drivers: one bus cycle, then sample 1 ns after the edge
  task automatic step(input logic [2:0] qv, input logic [31:0] pcv, input logic [31:0] instv,
                      input logic rw, input logic [31:0] alu);
    q = qv; pc = pcv; inst = instv; RegWre = rw; ALUout = alu;
    @(posedge clk);
    #1;
    if (model_run) exp_cycles++;
  endtask

  // One instruction: ID -> EXE -> WB -> IF; pc moves after decode, ALUout is noisy
  task automatic instr(input logic [31:0] pcv, input logic [31:0] instv, input logic wb,
                       input logic [31:0] wbv, input logic pop_last);
    step(Q_ID,   pcv,          instv, 1'b0, 32'h1111_1111);
    step(3'b110, pcv + 32'd4, instv, 1'b0, wbv ^ 32'h5A5A_5A5A);
    step(3'b111, pcv + 32'd4, instv, wb,   wb ? wbv : 32'hDEAD_BEEF);
    if (pop_last) tr_ready = 1'b1;
    step(Q_IF,   pcv + 32'd4, 32'h0,  1'b0, 32'hBEEF_0000);
    tr_ready = 1'b0;
  endtask

  // Scoreboard drain: pop everything and compare against exp_q in order
  task automatic drain(input int n_exp, input string tag);
    int n = 0;
    logic [96:0] e;
    tr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (!tr_valid) break;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_pc"},    tr_pc,              e[96:65]);
      check({tag, "_inst"},  tr_inst,            e[64:33]);
      check({tag, "_wb"},    {31'd0, tr_wb},     {31'd0, e[32]});
      check({tag, "_wbval"}, tr_wbval,           e[31:0]);
      n++;
      step(Q_IF, 32'h0, 32'h0, 1'b0, 32'h0);
    end
    tr_ready = 1'b0;
    check({tag, "_count"}, n, n_exp);
    check({tag, "_empty"}, {31'd0, tr_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; tr_ready = 1'b0;
    q = Q_IF; pc = '0; inst = '0; RegWre = 1'b0; ALUout = '0;

    // 1: reset with random bus
    for (int i = 0; i < 2; i++)
      step(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
    check("rst_valid",  {31'd0, tr_valid}, 32'd0);
    check("rst_pc",     tr_pc, 32'd0);
    check("rst_wbval",  tr_wbval, 32'd0);
    check("rst_cycle",  cycle_cnt, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_drop",   {24'd0, drop_cnt}, 32'd0);
    check("rst_ovf",    {31'd0, overflow}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_state",  {30'd0, state_o}, 32'd0);

    // IDLE -> RUN on first Q_IF; IF re-entry without a decode is not a retirement
    rst_n = 1'b1;
    step(Q_IF, 32'h0, 32'h0, 1'b0, 32'h0);
    model_run = 1;
    check("run_state", {30'd0, state_o}, 32'd1);
    step(3'b110, 32'h0, 32'h0, 1'b1, 32'h99);
    step(Q_IF,   32'h0, 32'h0, 1'b0, 32'h0);
    check("noid_retire", retire_cnt, 32'd0);
    check("noid_valid",  {31'd0, tr_valid}, 32'd0);

    // 2: single add with writeback
    instr(32'h4, 32'h0222_1800, 1'b1, 32'h7, 1'b0);
    exp_q.push_back(mk(32'h4, 32'h0222_1800, 1'b1, 32'h7));
    check("add_valid",  {31'd0, tr_valid}, 32'd1);
    check("add_pc",     tr_pc, 32'h4);
    check("add_inst",   tr_inst, 32'h0222_1800);
    check("add_wb",     {31'd0, tr_wb}, 32'd1);
    check("add_wbval",  tr_wbval, 32'h7);
    check("add_retire", retire_cnt, 32'd1);
    check("add_cycle",  cycle_cnt, 32'd6);
    drain(1, "add_drain");

    // 3: store, no writeback
    instr(32'h8, 32'hAC00_0000, 1'b0, 32'h0, 1'b0);
    exp_q.push_back(mk(32'h8, 32'hAC00_0000, 1'b0, 32'h0));
    check("sw_wb",     {31'd0, tr_wb}, 32'd0);
    check("sw_wbval",  tr_wbval, 32'd0);
    check("sw_retire", retire_cnt, 32'd2);
    drain(1, "sw_drain");

    // 4: overflow with consumer stalled
    for (int i = 0; i < DEPTH + 3; i++) begin
      instr(32'h100 + 32'(4 * i), 32'h20 | 32'(i << 11), 1'b1, 32'h1000 + 32'(i), 1'b0);
      if (i < DEPTH) exp_q.push_back(mk(32'h100 + 32'(4 * i), 32'h20 | 32'(i << 11), 1'b1,
                                        32'h1000 + 32'(i)));
    end
    check("ovf_valid",  {31'd0, tr_valid}, 32'd1);
    check("ovf_drop",   {24'd0, drop_cnt}, 32'd3);
    check("ovf_flag",   {31'd0, overflow}, 32'd1);
    check("ovf_retire", retire_cnt, 32'd13);
    check("ovf_head",   tr_pc, 32'h100);

    // 5: full FIFO, retire and pop on the same edge
    instr(32'h200, 32'h24, 1'b1, 32'h2000, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(32'h200, 32'h24, 1'b1, 32'h2000));
    check("fullpop_drop",   {24'd0, drop_cnt}, 32'd3);
    check("fullpop_retire", retire_cnt, 32'd14);
    check("fullpop_head",   tr_pc, 32'h104);
    drain(DEPTH, "full_drain");

    // 6: halt, activity ignored afterwards, then reset mid-drain
    instr(32'h300, 32'hFC00_0000, 1'b0, 32'h0, 1'b0);
    model_run = 0;
    check("halt_flag",   {31'd0, halted}, 32'd1);
    check("halt_state",  {30'd0, state_o}, 32'd2);
    check("halt_inst",   tr_inst, 32'hFC00_0000);
    check("halt_retire", retire_cnt, 32'd15);
    check("halt_cycle",  cycle_cnt, 32'(exp_cycles));
    instr(32'h304, 32'h0222_1800, 1'b1, 32'h9, 1'b0);
    check("post_retire", retire_cnt, 32'd15);
    check("post_cycle",  cycle_cnt, 32'(exp_cycles));
    check("post_head",   tr_pc, 32'h300);
    check("post_valid",  {31'd0, tr_valid}, 32'd1);

    tr_ready = 1'b1;
    rst_n = 1'b0;
    step(Q_IF, 32'h0, 32'h0, 1'b0, 32'h0);
    exp_q.delete();
    tr_ready = 1'b0;
    check("mid_rst_valid",  {31'd0, tr_valid}, 32'd0);
    check("mid_rst_cycle",  cycle_cnt, 32'd0);
    check("mid_rst_retire", retire_cnt, 32'd0);
    check("mid_rst_drop",   {24'd0, drop_cnt}, 32'd0);
    check("mid_rst_ovf",    {31'd0, overflow}, 32'd0);
    check("mid_rst_halted", {31'd0, halted}, 32'd0);
    check("mid_rst_state",  {30'd0, state_o}, 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
